// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N);

    int unsigned     j;
    logic [IW-1:0]   jj;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one APB port among NB_REQ requesters,
// with SETUP/ACCESS sequencing and an ACCESS timeout that turns hangs into errors.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NB_REQ         = 4,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = apb_arb_pkg::TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_REQ-1:0]                  req_i,
    input  logic [NB_REQ-1:0]                  we_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]                  gnt_o,
    output logic [NB_REQ-1:0]                  rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]          rdata_o,
    output logic                               err_o,
    output logic                               psel_o,
    output logic                               penable_o,
    output logic                               pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
    input  logic                               pready_i,
    input  logic                               pslverr_i
);

    localparam int unsigned IW = $clog2(NB_REQ);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    apb_arb_state_e state_q, state_d;

    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      we_q, we_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [NB_REQ-1:0]         arb_gnt;
    logic [IW-1:0]             arb_idx;
    logic                      timeout_hit;
    logic                      access_end;

    logic [APB_ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
    logic [APB_DATA_WIDTH-1:0] wdata_arr [NB_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            addr_arr[i]  = addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            wdata_arr[i] = wdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end
    end

    rr_arbiter #(
        .N(NB_REQ)
    ) u_rr_arbiter (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign access_end  = pready_i || timeout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A grant shown while reset is held would never be captured, so it is suppressed.
    always_comb begin
        gnt_o     = '0;
        rvalid_o  = '0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        unique case (state_q)
            IDLE:    if (rst_ni) gnt_o = arb_gnt;
            SETUP:   psel_o = 1'b1;
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            DONE:    rvalid_o[idx_q] = 1'b1;
            default: ;
        endcase
    end

    // Request fields are cleared as ACCESS ends so the APB outputs read 0 in DONE/IDLE
    // straight from the registers; completion data lives only for the DONE cycle.
    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    idx_d   = arb_idx;
                    ptr_d   = (arb_idx == IW'(NB_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    we_d    = we_i[arb_idx];
                    addr_d  = addr_arr[arb_idx];
                    wdata_d = wdata_arr[arb_idx];
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (pready_i) begin
                    rdata_d = we_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
                if (access_end) begin
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwrite_o = we_q;
    assign paddr_o  = addr_q;
    assign pwdata_o = wdata_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: single write, round robin, wait states,
// timeout, pready/timeout race, slave error and reset during ACCESS.
module tb_apb_master_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, we;
    logic [127:0] addr, wdata;
    logic [3:0]   gnt, rvalid;
    logic [31:0]  rdata, paddr, pwdata, prdata;
    logic         err, psel, penable, pwrite, pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .NB_REQ(4),
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    task automatic test_reset();
        #1;
        checks++;
        if ({gnt, rvalid, psel, penable, pwrite, err} !== 12'h000 || paddr !== 32'h0 ||
            pwdata !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b rvalid=%b psel=%b pen=%b pw=%b err=%b paddr=%h pwdata=%h rdata=%h want all 0",
                     gnt, rvalid, psel, penable, pwrite, err, paddr, pwdata, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req = 4'b0001; we = 4'b0001; addr[31:0] = 32'h1A10_0000; wdata[31:0] = 32'hDEAD_BEEF;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h7777_7777;
        #1;
        checks++;
        if (gnt !== 4'b0001 || psel !== 1'b0) begin
            errors++; $display("FAIL wr_gnt gnt=%b psel=%b want 0001/0", gnt, psel);
        end
        @(negedge clk);
        req = 4'b0000; we = 4'b0000; addr[31:0] = 32'h0; wdata[31:0] = 32'h0;
        #1;
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h1A10_0000 ||
            pwdata !== 32'hDEAD_BEEF || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL wr_setup sel/en/wr=%b paddr=%h pwdata=%h gnt=%b want 101 1a100000 deadbeef 0000",
                     {psel, penable, pwrite}, paddr, pwdata, gnt);
        end
        @(negedge clk); #1;
        checks++;
        if ({psel, penable} !== 2'b11 || paddr !== 32'h1A10_0000 || rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL wr_access sel/en=%b paddr=%h rvalid=%b want 11 1a100000 0000",
                     {psel, penable}, paddr, rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 4'b0001 || err !== 1'b0 || rdata !== 32'h0 || {psel, penable, pwrite} !== 3'b000 ||
            paddr !== 32'h0 || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_done rvalid=%b err=%b rdata=%h sel/en/wr=%b paddr=%h pwdata=%h want 0001 0 0 000 0 0",
                     rvalid, err, rdata, {psel, penable, pwrite}, paddr, pwdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL wr_idle rvalid=%b err=%b want 0000/0", rvalid, err);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t == 0) begin
                req = 4'b1111; we = 4'b0000; pready = 1'b1; pslverr = 1'b0;
            end
            prdata = 32'hA000_0000 + 32'(t);
            exp_oh = 4'b0001 << (t % 4);
            #1;
            checks++;
            if (gnt !== exp_oh) begin
                errors++; $display("FAIL rr_gnt[%0d] got=%b want=%b", t, gnt, exp_oh);
            end
            @(negedge clk); @(negedge clk); @(negedge clk);
            if (t == 4) req = 4'b0000;
            #1;
            checks++;
            if (rvalid !== exp_oh || rdata !== 32'hA000_0000 + 32'(t)) begin
                errors++;
                $display("FAIL rr_done[%0d] rvalid=%b rdata=%h want %b %h", t, rvalid, rdata, exp_oh,
                         32'hA000_0000 + 32'(t));
            end
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        req = 4'b0010; we = 4'b0000; addr[63:32] = 32'h1A10_1000; pready = 1'b0; prdata = 32'h0;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL ws_gnt got=%b want=0010", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        checks++;
        if ({psel, penable} !== 2'b10 || paddr !== 32'h1A10_1000) begin
            errors++; $display("FAIL ws_setup sel/en=%b paddr=%h want 10 1a101000", {psel, penable}, paddr);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk); #1;
            checks++;
            if ({psel, penable} !== 2'b11 || rvalid !== 4'b0000) begin
                errors++; $display("FAIL ws_wait[%0d] sel/en=%b rvalid=%b want 11 0000", w, {psel, penable}, rvalid);
            end
        end
        @(negedge clk);
        pready = 1'b1; prdata = 32'h1234_5678;
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        #1;
        checks++;
        if (rvalid !== 4'b0010 || rdata !== 32'h1234_5678 || err !== 1'b0) begin
            errors++;
            $display("FAIL ws_done rvalid=%b rdata=%h err=%b want 0010 12345678 0", rvalid, rdata, err);
        end
    endtask

    task automatic test_timeout();
        int  acc;
        bit  left;
        @(negedge clk);
        req = 4'b0100; we = 4'b0000; addr[95:64] = 32'hF000_0000; pready = 1'b0; prdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL to_gnt got=%b want=0100", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        acc = 0; left = 1'b0;
        for (int i = 0; i < 40 && !left; i++) begin
            @(negedge clk); #1;
            if (penable) acc++;
            else left = 1'b1;
        end
        checks++;
        if (acc != 8 || rvalid !== 4'b0100 || err !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_done access_cycles=%0d rvalid=%b err=%b rdata=%h want 8 0100 1 0", acc, rvalid, err, rdata);
        end
    endtask

    task automatic test_timeout_race();
        bit ok;
        @(negedge clk);
        req = 4'b1000; we = 4'b0000; pready = 1'b0; prdata = 32'hCAFE_0001; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++; $display("FAIL race_gnt got=%b want=1000", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            if (penable !== 1'b1 || rvalid !== 4'b0000) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL race_wait ended early ok=%b want 1", ok);
        end
        @(negedge clk);
        pready = 1'b1;
        @(negedge clk);
        pready = 1'b0;
        #1;
        checks++;
        if (rvalid !== 4'b1000 || err !== 1'b0 || rdata !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL race_done rvalid=%b err=%b rdata=%h want 1000 0 cafe0001", rvalid, err, rdata);
        end
    endtask

    task automatic test_slverr();
        @(negedge clk);
        req = 4'b1000; we = 4'b1000; addr[127:96] = 32'h1A10_2000; wdata[127:96] = 32'h0BAD_F00D;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h9999_9999;
        @(negedge clk); req = 4'b0000; we = 4'b0000;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 4'b1000 || err !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL slverr_done rvalid=%b err=%b rdata=%h want 1000 1 0", rvalid, err, rdata);
        end
        @(negedge clk);
        req = 4'b0001; we = 4'b0000; addr[31:0] = 32'h1A10_0004; pslverr = 1'b0; prdata = 32'h0000_0055;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL slverr_next_gnt got=%b want=0001", gnt);
        end
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 4'b0001 || err !== 1'b0 || rdata !== 32'h0000_0055) begin
            errors++; $display("FAIL slverr_next_done rvalid=%b err=%b rdata=%h want 0001 0 55", rvalid, err, rdata);
        end
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        req = 4'b0001; we = 4'b0000; pready = 1'b0; prdata = 32'h0;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL rst_pre_gnt got=%b want=0001", gnt);
        end
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk); #1;
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++; $display("FAIL rst_in_access sel/en=%b want 11", {psel, penable});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable} !== 2'b00 || rvalid !== 4'b0000 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rst_abort sel/en=%b rvalid=%b gnt=%b want 00 0000 0000", {psel, penable}, rvalid, gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100 || rvalid !== 4'b0000) begin
            errors++; $display("FAIL rst_post_gnt gnt=%b rvalid=%b want 0100 0000", gnt, rvalid);
        end
        @(negedge clk); req = 4'b0000; pready = 1'b1;
        #1;
        checks++;
        if (rvalid !== 4'b0000 || psel !== 1'b1) begin
            errors++; $display("FAIL rst_no_stale_rvalid rvalid=%b psel=%b want 0000 1", rvalid, psel);
        end
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 4'b0100) begin
            errors++; $display("FAIL rst_post_done rvalid=%b want 0100", rvalid);
        end
        // Pointer now sits at 3; a fresh reset must bring it back to 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        req = 4'b1001; rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL rst_ptr_zero gnt=%b want 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000; pready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_timeout_race();
        test_slverr();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
